// File: rtl/seq_mult_rca_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_mult_rca_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_rca_rca_nbit.sv
// N-bit ripple-carry adder built as a chain of 4-bit ripple cells.
module rca_nbit #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         carry_in,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    localparam int unsigned Cells = N / 4;

    if ((N % 4) != 0 || N < 4 || N > 32) begin : g_bad_width
        $error("rca_nbit: N must be a multiple of 4 in 4..32");
    end

    always_comb begin : p_chain
        logic c;
        sum = '0;
        c   = carry_in;
        for (int g = 0; g < Cells; g++) begin
            for (int i = 0; i < 4; i++) begin
                sum[4*g+i] = x[4*g+i] ^ y[4*g+i] ^ c;
                c          = (x[4*g+i] & y[4*g+i]) | (c & (x[4*g+i] ^ y[4*g+i]));
            end
        end
        carry_out = c;
    end

endmodule

// File: rtl/seq_mult_rca.sv
// Unsigned N x N -> 2N shift-and-add multiplier; one ripple-carry add per cycle.
module seq_mult_rca
    import seq_mult_rca_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = cnt_width(N);

    state_e         state_q, state_d;
    logic [N-1:0]   m_q;
    logic [2*N-1:0] p_q;
    logic [2*N-1:0] product_q;
    logic [CW-1:0]  count_q;

    logic           accept;
    logic           last;
    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           carry;
    logic [2*N-1:0] p_shift;

    // DONE behaves like IDLE for a new request; RUN ignores start.
    assign accept  = start && (state_q != StRun);
    assign last    = (count_q == CW'(N - 1));
    assign addend  = p_q[0] ? m_q : '0;
    // The carry becomes the new MSB, so no bit of the partial sum is lost.
    assign p_shift = {carry, sum, p_q[N-1:1]};

    rca_nbit #(
        .N(N)
    ) u_rca (
        .x        (p_q[2*N-1:N]),
        .y        (addend),
        .carry_in (1'b0),
        .sum      (sum),
        .carry_out(carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StRun:   busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            p_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else if (accept) begin
            m_q     <= a;
            p_q     <= {{N{1'b0}}, b};
            count_q <= '0;
        end else if (state_q == StRun) begin
            p_q     <= p_shift;
            count_q <= count_q + CW'(1);
            if (last) begin
                product_q <= p_shift;
            end
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_rca.sv
// Randomised and directed checks of seq_mult_rca against plain a*b arithmetic.
module tb_seq_mult_rca;

    localparam int unsigned N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int             total;
    int             bad;
    logic [2*N-1:0] last_prod;

    seq_mult_rca #(
        .N(N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge where done is high (or after the bound).
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input int glitch);
        logic [2*N-1:0] exp;
        int             busy_cnt;
        bit             seen;
        exp      = {{N{1'b0}}, ta} * {{N{1'b0}}, tb};
        start    = 1'b1;
        a        = ta;
        b        = tb;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 1; i <= 4 * N && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                check_eq("prod_hold", 64'(product), 64'(last_prod));
                if (i == glitch) begin
                    start = 1'b1;
                    a     = 9;
                    b     = 9;
                end else begin
                    start = 1'b0;
                    a     = N'($urandom());
                    b     = N'($urandom());
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_eq("done_seen", 64'(seen), 64'(1));
        check_eq("busy_cycles", 64'(busy_cnt), 64'(N));
        check_eq("busy_in_done", 64'(busy), 64'(0));
        check_eq("product", 64'(product), 64'(exp));
        last_prod = exp;
    endtask

    task automatic go_idle();
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'(0));
        check_eq("idle_busy", 64'(busy), 64'(0));
        check_eq("idle_prod", 64'(product), 64'(last_prod));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        last_prod = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_prod", 64'(product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd13, 8'd11, 0);
        check_eq("p_13x11", 64'(product), 64'h008F);
        go_idle();
        run_op(8'd255, 8'd255, 0);
        check_eq("p_255x255", 64'(product), 64'hFE01);
        go_idle();
        run_op(8'd0, 8'd200, 0);
        go_idle();
        run_op(8'd77, 8'd0, 0);
        go_idle();

        // start pulse at RUN cycle 3 must be ignored; next start lands in DONE.
        run_op(8'd6, 8'd7, 3);
        check_eq("p_6x7", 64'(product), 64'd42);
        run_op(8'd200, 8'd3, 0);
        check_eq("p_200x3", 64'(product), 64'h0258);
        go_idle();

        for (int k = 0; k < 16; k++) begin
            run_op(N'($urandom()), N'($urandom()), int'($urandom_range(0, N + 2)));
            if ($urandom_range(0, 1) == 1) go_idle();
        end

        go_idle();
        run_op(8'd3, 8'd4, 0);
        go_idle();
        start = 1'b1;
        a     = 8'd77;
        b     = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'(0));
        check_eq("arst_done", 64'(done), 64'(0));
        check_eq("arst_prod", 64'(product), 64'(0));
        last_prod = '0;
        repeat (2) @(negedge clk);
        check_eq("arst_hold", 64'(busy), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", 64'(busy), 64'(0));
        run_op(8'd5, 8'd5, 0);
        check_eq("p_5x5", 64'(product), 64'd25);
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mult_rca.md
Name: seq_mult_rca

Overview:
Sequential unsigned shift-and-add multiplier, N x N -> 2N bits.
Each iteration's partial-product addition runs through an N-bit ripple-carry adder chain. The block registers the sum and carry every cycle and feeds them back as the next addend.
The block sits directly downstream of the ripple-carry adder: it is the first sequential consumer of the adder's sum/carry_out. It is the datapath-plus-controller for the team's multiplier assignment.

Parameters:
N, 8, operand width in bits; must be a multiple of 4 (adder built from 4-bit ripple-carry cells); legal range 4..32.

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request to begin a multiplication; sampled on rising clk.
a  input  N  multiplicand; sampled only on an accepted start.
b  input  N  multiplier; sampled only on an accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when product becomes valid.
product  output  2N  result register; holds last completed product.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). Assertion of rst_n=0 immediately forces state=IDLE, busy=0, done=0, product=0, and all internal regs (M, P, count) = 0. Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN, DONE. Encodings live in the shared header.
- IDLE:
  - start=1 at edge E0 -> load M<=a, P<={N'b0, b}, count<=0; go RUN; busy=1 from cycle after E0.
  - start=0 -> stay IDLE.
- RUN, one iteration per edge, N edges (E1..EN):
  - addend = P[0] ? M : 0.
  - {c, s} = P[2N-1:N] + addend via the N-bit ripple adder (carry_in=0).
  - P <= {c, s, P[N-1:1]} (logical right shift including carry); count <= count+1.
  - At edge EN (count==N-1): product <= the shifted result; go DONE; busy<=0; done<=1.
- DONE: exactly one cycle with done=1, busy=0. Behaves as IDLE for start: if start=1 here, the new operation is accepted, with the same effect as the IDLE accept. Otherwise return IDLE. done deasserts at the next edge in either case.
- Latency: start accepted at E0 -> done high in the cycle following EN (N+1 edges after acceptance). Throughput: one result per N+1 cycles.
- start while busy=1 (RUN): ignored; a/b not sampled; no queueing.
- product changes only at EN of a completed operation; it is stable through IDLE/DONE and during a subsequent RUN.
- Width rules: all arithmetic unsigned. The adder carry is never dropped, because it is shifted into P[2N-1]. Max result (2^N-1)^2 fits in 2N bits.
- Operand zero: no early termination; always N iterations.
- Reset mid-RUN: operation aborted; product=0; no done pulse; next start begins fresh.
- a/b changes during RUN have no effect.

Decomposition:
- Shared header mult_defs.vh: state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10), count width macro ($clog2(N)).
- One sub-module: rca_nbit (parameter N). Combinational chain of N/4 4-bit ripple-carry adder cells; ports x, y, carry_in, sum, carry_out.
- FSM, counter and P/M/product registers stay in seq_mult_rca.

Test Plan:
- N=8; reset, then start 1 cycle with a=13, b=11 -> busy high 8 cycles; done pulses 9 edges after accept; product=16'h008F, held afterwards.
- a=255, b=255 -> product=16'hFE01. Checks adder carry shifted into MSB on every iteration.
- a=0, b=200 and a=77, b=0 -> product=0 in both; still exactly 8 busy cycles; done pulses once each.
- After a=6, b=7 accepted, pulse start with a=9, b=9 at RUN cycle 3 -> ignored; product=42; busy duration unchanged.
- Start asserted during the DONE cycle of 6*7 with a=200, b=3 -> accepted immediately; busy next cycle; later product=600 (16'h0258); 42 visible until then.
- rst_n low asynchronously mid-RUN (between edges) -> busy, done, product go 0 without a clk edge. After release, 5*5 completes with product=25.
